// File: rtl/exception_ctrl.sv
// Commit-stage exception/interrupt/ERET resolver with a flush -> redirect handshake.
// The winning event is captured in IDLE and replayed as one CP0 write or ERET strobe.
module exception_ctrl #(
    parameter int                        NUM_SRC      = 12,
    parameter int                        NUM_IRQ      = 8,
    parameter int                        CODE_W       = 5,
    parameter logic [NUM_SRC*CODE_W-1:0] SRC_CODES    = {5'h0D, 5'h0C, 5'h09, 5'h08, 5'h0A, 5'h0B,
                                                         5'h05, 5'h04, 5'h03, 5'h02, 5'h02, 5'h04},
    parameter logic [NUM_SRC-1:0]        REFILL_MASK  = '0,
    parameter logic [CODE_W-1:0]         INT_CODE     = '0,
    parameter logic [31:0]               EXC_ENTRY    = 32'hBFC0_0380,
    parameter logic [31:0]               REFILL_ENTRY = 32'hBFC0_0200
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               req_valid,
    input  logic [NUM_SRC-1:0] src,
    input  logic               is_eret,
    input  logic [31:0]        pc,
    input  logic               in_delay_slot,
    input  logic [31:0]        badvaddr,
    input  logic [NUM_IRQ-1:0] irq_ext,
    input  logic               status_ie,
    input  logic               status_exl,
    input  logic               status_erl,
    input  logic [NUM_IRQ-1:0] status_im,
    input  logic [31:0]        epc,
    input  logic               pipe_drained,
    output logic               accept,
    output logic               flush,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    output logic               cp0_we,
    output logic               eret_done,
    output logic [CODE_W-1:0]  exc_code,
    output logic [31:0]        exc_pc,
    output logic               exc_bd,
    output logic [31:0]        exc_badvaddr,
    output logic [NUM_IRQ-1:0] ip_pending
);

    typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

    state_t               state_reg, state_next;
    logic [NUM_IRQ-1:0]   irq_meta_reg, irq_sync_reg;
    logic [CODE_W-1:0]    code_reg;
    logic [31:0]          pc_reg, badvaddr_reg, target_reg;
    logic                 bd_reg, eret_reg;

    logic [CODE_W-1:0]    code_tab [NUM_SRC];
    logic [CODE_W-1:0]    sel_code, capture_code;
    logic                 sel_refill;
    logic                 int_hit, exc_hit, take;
    logic [31:0]          capture_target, capture_pc;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_code
        assign code_tab[gi] = SRC_CODES[gi*CODE_W +: CODE_W];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_meta_reg <= '0;
            irq_sync_reg <= '0;
        end else begin
            irq_meta_reg <= irq_ext;
            irq_sync_reg <= irq_meta_reg;
        end
    end

    assign ip_pending = irq_sync_reg;
    assign int_hit    = (|(irq_sync_reg & status_im)) & status_ie & ~status_exl & ~status_erl;
    assign exc_hit    = int_hit | (|src);

    // Scan from the lowest priority upward so the lowest set index overwrites the rest.
    always_comb begin
        sel_code   = '0;
        sel_refill = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src[i]) begin
                sel_code   = code_tab[i];
                sel_refill = REFILL_MASK[i];
            end
        end
    end

    assign capture_code   = int_hit ? INT_CODE : sel_code;
    assign capture_target = int_hit    ? EXC_ENTRY :
                            (|src)     ? (sel_refill ? REFILL_ENTRY : EXC_ENTRY) :
                                         epc;
    assign capture_pc     = in_delay_slot ? (pc - 32'd4) : pc;
    assign take           = (state_reg == IDLE) & req_valid & (exc_hit | is_eret);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            code_reg     <= '0;
            pc_reg       <= '0;
            bd_reg       <= 1'b0;
            badvaddr_reg <= '0;
            target_reg   <= '0;
            eret_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (take) begin
                code_reg     <= capture_code;
                pc_reg       <= capture_pc;
                bd_reg       <= in_delay_slot;
                badvaddr_reg <= badvaddr;
                target_reg   <= capture_target;
                eret_reg     <= ~exc_hit;
            end
        end
    end

    // Strobes decode from the state alone, which keeps them mutually exclusive.
    always_comb begin
        state_next     = state_reg;
        accept         = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        cp0_we         = 1'b0;
        eret_done      = 1'b0;
        case (state_reg)
            IDLE: begin
                accept = 1'b1;
                if (take) state_next = FLUSH;
            end
            FLUSH: begin
                flush = 1'b1;
                if (pipe_drained) state_next = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                cp0_we         = ~eret_reg;
                eret_done      = eret_reg;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign redirect_pc  = target_reg;
    assign exc_code     = code_reg;
    assign exc_pc       = pc_reg;
    assign exc_bd       = bd_reg;
    assign exc_badvaddr = badvaddr_reg;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed and random transactions for exception_ctrl, checked against a
// priority/vector model derived from the event rules.
module tb_exception_ctrl;

    localparam logic [59:0] CODES = {5'h0F, 5'h05, 5'h01, 5'h0B, 5'h0D, 5'h09,
                                     5'h08, 5'h0A, 5'h0C, 5'h03, 5'h02, 5'h04};
    localparam logic [11:0] RMASK = 12'b0000_0000_0110;
    localparam logic [4:0]  ICODE = 5'h00;
    localparam logic [31:0] EXCV  = 32'hBFC0_0380;
    localparam logic [31:0] REFV  = 32'hBFC0_0200;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic [11:0] src = '0;
    logic        is_eret = 1'b0;
    logic [31:0] pc = '0;
    logic        in_delay_slot = 1'b0;
    logic [31:0] badvaddr = '0;
    logic [7:0]  irq_ext = '0;
    logic        status_ie = 1'b0, status_exl = 1'b0, status_erl = 1'b0;
    logic [7:0]  status_im = '0;
    logic [31:0] epc = '0;
    logic        pipe_drained = 1'b0;
    logic        accept, flush, redirect_valid, cp0_we, eret_done, exc_bd;
    logic [31:0] redirect_pc, exc_pc, exc_badvaddr;
    logic [4:0]  exc_code;
    logic [7:0]  ip_pending;

    int total = 0;
    int bad   = 0;

    exception_ctrl #(
        .NUM_SRC(12), .NUM_IRQ(8), .CODE_W(5), .SRC_CODES(CODES), .REFILL_MASK(RMASK),
        .INT_CODE(ICODE), .EXC_ENTRY(EXCV), .REFILL_ENTRY(REFV)
    ) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .src(src), .is_eret(is_eret),
        .pc(pc), .in_delay_slot(in_delay_slot), .badvaddr(badvaddr), .irq_ext(irq_ext),
        .status_ie(status_ie), .status_exl(status_exl), .status_erl(status_erl),
        .status_im(status_im), .epc(epc), .pipe_drained(pipe_drained), .accept(accept),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .cp0_we(cp0_we), .eret_done(eret_done), .exc_code(exc_code), .exc_pc(exc_pc),
        .exc_bd(exc_bd), .exc_badvaddr(exc_badvaddr), .ip_pending(ip_pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic want);
        chk(tag, 32'(obs), 32'(want));
    endtask

    // Reference: interrupt beats sources, the lowest set source index wins, ERET is last.
    function automatic void model(input logic [11:0] s, input logic er, input logic [7:0] ip,
                                  input logic [31:0] e, output bit taken, output bit eret,
                                  output logic [4:0] code, output logic [31:0] target);
        logic [11:0] low;
        int          idx;
        bit          ihit;
        ihit   = ((ip & status_im) != 0) && status_ie && !status_exl && !status_erl;
        taken  = 1'b1;
        eret   = 1'b0;
        code   = '0;
        target = '0;
        if (ihit) begin
            code   = ICODE;
            target = EXCV;
        end else if (s != 0) begin
            low    = s & (~s + 12'd1);
            idx    = $countones(low - 12'd1);
            code   = CODES[idx*5 +: 5];
            target = RMASK[idx] ? REFV : EXCV;
        end else if (er) begin
            eret   = 1'b1;
            target = e;
        end else begin
            taken = 1'b0;
        end
    endfunction

    task automatic request(input logic [11:0] s, input logic er, input logic [31:0] p,
                           input logic bd, input logic [31:0] bva, input logic [31:0] e);
        req_valid = 1'b1; src = s; is_eret = er; pc = p; in_delay_slot = bd;
        badvaddr = bva; epc = e;
        chk1("idle_accept", accept, 1'b1);
        tick();
    endtask

    // Called right after the capture edge; walks FLUSH (with junk inputs), REDIRECT, IDLE.
    task automatic expect_txn(input logic [4:0] code, input logic [31:0] epcv, input logic bd,
                              input logic [31:0] bva, input logic [31:0] target,
                              input logic er, input int drain);
        for (int k = 0; k <= drain; k++) begin
            chk1("flush_hi", flush, 1'b1);
            chk1("flush_accept", accept, 1'b0);
            chk1("flush_redir", redirect_valid, 1'b0);
            chk1("flush_we", cp0_we | eret_done, 1'b0);
            req_valid = 1'($urandom); src = 12'($urandom); is_eret = 1'($urandom);
            epc = $urandom; pc = $urandom; badvaddr = $urandom; in_delay_slot = 1'($urandom);
            pipe_drained = (k == drain);
            tick();
        end
        req_valid = 1'b0; pipe_drained = 1'b0;
        chk1("redir_valid", redirect_valid, 1'b1);
        chk("redir_pc", redirect_pc, target);
        chk1("redir_flush", flush, 1'b0);
        chk1("redir_cp0_we", cp0_we, !er);
        chk1("redir_eret_done", eret_done, er);
        if (!er) begin
            chk("exc_code", 32'(exc_code), 32'(code));
            chk("exc_pc", exc_pc, epcv);
            chk1("exc_bd", exc_bd, bd);
            chk("exc_badvaddr", exc_badvaddr, bva);
        end
        tick();
        chk1("back_accept", accept, 1'b1);
        chk1("back_strobes", flush | redirect_valid | cp0_we | eret_done, 1'b0);
    endtask

    initial begin
        bit          taken, er_m;
        logic [4:0]  code_m;
        logic [31:0] tgt_m;
        logic [11:0] s_r;
        logic        er_r, bd_r;
        logic [31:0] pc_r, bva_r, epc_r;

        // Reset state
        tick(); tick(); tick();
        chk1("rst_accept", accept, 1'b1);
        chk1("rst_strobes", flush | redirect_valid | cp0_we | eret_done, 1'b0);
        chk("rst_code", 32'(exc_code), 32'd0);
        chk("rst_pc", exc_pc, 32'd0);
        chk1("rst_bd", exc_bd, 1'b0);
        chk("rst_bva", exc_badvaddr, 32'd0);
        chk("rst_redir_pc", redirect_pc, 32'd0);
        chk("rst_ip", 32'(ip_pending), 32'd0);
        resetn = 1'b1;
        tick();

        // src[3], delay slot, minimum latency
        request(12'h008, 1'b0, 32'h8000_1000, 1'b1, 32'h1234_5678, 32'h0);
        expect_txn(5'h0C, 32'h8000_0FFC, 1'b1, 32'h1234_5678, EXCV, 1'b0, 0);

        // src[1] and src[4]: refill vector for index 1
        request(12'h012, 1'b0, 32'h8000_0040, 1'b0, 32'hDEAD_BEEF, 32'h0);
        expect_txn(5'h02, 32'h8000_0040, 1'b0, 32'hDEAD_BEEF, REFV, 1'b0, 1);

        // src[11] in delay slot with pc below 4 wraps
        request(12'h800, 1'b0, 32'h0000_0002, 1'b1, 32'h0, 32'h0);
        expect_txn(5'h0F, 32'hFFFF_FFFE, 1'b1, 32'h0, EXCV, 1'b0, 0);

        // Interrupt synchroniser latency with EXL masking the take
        status_ie = 1'b1; status_exl = 1'b1; status_im = 8'h04;
        irq_ext = 8'h04;
        tick();
        chk("irq_edge1", 32'(ip_pending), 32'h00);
        tick();
        chk("irq_edge2", 32'(ip_pending), 32'h04);
        request(12'h000, 1'b0, 32'h8000_0100, 1'b0, 32'h0, 32'h0);
        chk1("exl_no_take", flush, 1'b0);
        req_valid = 1'b0;
        irq_ext = 8'h00;
        tick(); tick(); tick();
        status_exl = 1'b0;

        // Held request: interrupt taken only once ip_pending rises
        irq_ext = 8'h04; req_valid = 1'b1; src = '0; is_eret = 1'b0;
        pc = 32'h8000_0200; in_delay_slot = 1'b0; badvaddr = 32'h0;
        tick();
        chk1("irq_wait1", flush, 1'b0);
        tick();
        chk1("irq_wait2", flush, 1'b0);
        tick();
        expect_txn(ICODE, 32'h8000_0200, 1'b0, 32'h0, EXCV, 1'b0, 0);

        // Pending interrupt beats src[0]
        request(12'h001, 1'b0, 32'h8000_0300, 1'b0, 32'h5555_0000, 32'h0);
        expect_txn(ICODE, 32'h8000_0300, 1'b0, 32'h5555_0000, EXCV, 1'b0, 0);
        status_ie = 1'b0; irq_ext = 8'h00;

        // ERET with a stalled drain
        request(12'h000, 1'b1, 32'h8000_0400, 1'b0, 32'h0, 32'h8000_2000);
        expect_txn(5'h00, 32'h0, 1'b0, 32'h0, 32'h8000_2000, 1'b1, 5);

        // ERET with src[0]: exception wins
        request(12'h001, 1'b1, 32'h8000_0500, 1'b0, 32'hAAAA_0000, 32'h8000_2000);
        expect_txn(5'h04, 32'h8000_0500, 1'b0, 32'hAAAA_0000, EXCV, 1'b0, 0);

        // Reset during FLUSH aborts the sequence
        request(12'h001, 1'b0, 32'h8000_0600, 1'b0, 32'h0, 32'h0);
        chk1("pre_rst_flush", flush, 1'b1);
        req_valid = 1'b0;
        resetn = 1'b0;
        #1;
        chk1("arst_flush", flush, 1'b0);
        chk1("arst_accept", accept, 1'b1);
        chk1("arst_strobes", redirect_valid | cp0_we | eret_done, 1'b0);
        chk("arst_code", 32'(exc_code), 32'd0);
        pipe_drained = 1'b1;
        tick();
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk1("post_rst_strobes", flush | redirect_valid | cp0_we | eret_done, 1'b0);
            chk1("post_rst_accept", accept, 1'b1);
        end
        pipe_drained = 1'b0;

        // Random transactions against the model
        for (int n = 0; n < 40; n++) begin
            irq_ext = 8'($urandom); status_im = 8'($urandom);
            status_ie = 1'($urandom); status_exl = 1'($urandom % 4 == 0);
            status_erl = 1'($urandom % 4 == 0);
            req_valid = 1'b0;
            tick(); tick();
            chk("rnd_ip", 32'(ip_pending), 32'(irq_ext));
            s_r   = ($urandom % 3 == 0) ? 12'h000 : 12'($urandom & $urandom);
            er_r  = 1'($urandom); bd_r = 1'($urandom);
            pc_r  = $urandom; bva_r = $urandom; epc_r = $urandom;
            model(s_r, er_r, irq_ext, epc_r, taken, er_m, code_m, tgt_m);
            request(s_r, er_r, pc_r, bd_r, bva_r, epc_r);
            if (taken) begin
                expect_txn(code_m, bd_r ? pc_r - 32'd4 : pc_r, bd_r, bva_r, tgt_m, er_m,
                           int'($urandom_range(0, 3)));
            end else begin
                chk1("rnd_no_take_flush", flush, 1'b0);
                chk1("rnd_no_take_accept", accept, 1'b1);
                req_valid = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
